// File: rtl/rf_wb_arb.sv
// Round-robin arbiter merging three writeback requesters onto two register-file write ports, plus a pending-register scoreboard.
// Grant is combinational (ready), the write is registered one cycle later; an ungranted request keeps ready low and must hold.
module rf_wb_arb #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb0_valid,
    output logic            wb0_ready,
    input  logic [4:0]      wb0_dst,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_valid,
    output logic            wb1_ready,
    input  logic [4:0]      wb1_dst,
    input  logic [XLEN-1:0] wb1_data,
    input  logic            wb2_valid,
    output logic            wb2_ready,
    input  logic [4:0]      wb2_dst,
    input  logic [XLEN-1:0] wb2_data,
    output logic            rf_wen0,
    output logic [4:0]      rf_wdst0,
    output logic [XLEN-1:0] rf_wdata0,
    output logic            rf_wen1,
    output logic [4:0]      rf_wdst1,
    output logic [XLEN-1:0] rf_wdata1,
    input  logic            sb_set_valid,
    input  logic [4:0]      sb_set_dst,
    output logic [31:0]     sb_busy
);

    logic [1:0]      r_rr_ptr;
    logic            r_wen0, r_wen1;
    logic [4:0]      r_wdst0, r_wdst1;
    logic [XLEN-1:0] r_wdata0, r_wdata1;
    logic [31:0]     r_busy;

    logic            w_vld [3];
    logic [4:0]      w_dst [3];
    logic [XLEN-1:0] w_dat [3];
    logic [1:0]      w_ord [3];
    logic [2:0]      w_gnt;
    logic            w_p0_vld, w_p1_vld;
    logic [1:0]      w_p0_idx, w_p1_idx;
    logic [31:0]     w_busy_nxt;

    assign w_vld[0] = wb0_valid;
    assign w_vld[1] = wb1_valid;
    assign w_vld[2] = wb2_valid;
    assign w_dst[0] = wb0_dst;
    assign w_dst[1] = wb1_dst;
    assign w_dst[2] = wb2_dst;
    assign w_dat[0] = wb0_data;
    assign w_dat[1] = wb1_data;
    assign w_dat[2] = wb2_data;

    always_comb begin
        w_ord[0] = 2'd0;
        w_ord[1] = 2'd1;
        w_ord[2] = 2'd2;
        case (r_rr_ptr)
            2'd1: begin w_ord[0] = 2'd1; w_ord[1] = 2'd2; w_ord[2] = 2'd0; end
            2'd2: begin w_ord[0] = 2'd2; w_ord[1] = 2'd0; w_ord[2] = 2'd1; end
            default: ;
        endcase
    end

    // x0 writes are accepted for free; a second write to the same register waits a cycle
    always_comb begin
        w_gnt    = 3'b000;
        w_p0_vld = 1'b0;
        w_p0_idx = 2'd0;
        w_p1_vld = 1'b0;
        w_p1_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!rst && w_vld[w_ord[k]]) begin
                if (w_dst[w_ord[k]] == 5'd0) begin
                    w_gnt[w_ord[k]] = 1'b1;
                end else if (!w_p0_vld) begin
                    w_gnt[w_ord[k]] = 1'b1;
                    w_p0_vld        = 1'b1;
                    w_p0_idx        = w_ord[k];
                end else if (!w_p1_vld && (w_dst[w_ord[k]] != w_dst[w_p0_idx])) begin
                    w_gnt[w_ord[k]] = 1'b1;
                    w_p1_vld        = 1'b1;
                    w_p1_idx        = w_ord[k];
                end
            end
        end
    end

    assign wb0_ready = w_gnt[0];
    assign wb1_ready = w_gnt[1];
    assign wb2_ready = w_gnt[2];

    // Clears land on the edge the register file commits; a same-cycle set wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen0) w_busy_nxt[r_wdst0] = 1'b0;
        if (r_wen1) w_busy_nxt[r_wdst1] = 1'b0;
        if (sb_set_valid) w_busy_nxt[sb_set_dst] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 2'd0;
            r_wen0   <= 1'b0;
            r_wen1   <= 1'b0;
            r_wdst0  <= '0;
            r_wdst1  <= '0;
            r_wdata0 <= '0;
            r_wdata1 <= '0;
            r_busy   <= '0;
        end else begin
            if (w_p0_vld) r_rr_ptr <= (w_p0_idx == 2'd2) ? 2'd0 : w_p0_idx + 2'd1;
            r_wen0 <= w_p0_vld;
            r_wen1 <= w_p1_vld;
            if (w_p0_vld) begin
                r_wdst0  <= w_dst[w_p0_idx];
                r_wdata0 <= w_dat[w_p0_idx];
            end
            if (w_p1_vld) begin
                r_wdst1  <= w_dst[w_p1_idx];
                r_wdata1 <= w_dat[w_p1_idx];
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign rf_wen0   = r_wen0;
    assign rf_wdst0  = r_wdst0;
    assign rf_wdata0 = r_wdata0;
    assign rf_wen1   = r_wen1;
    assign rf_wdst1  = r_wdst1;
    assign rf_wdata1 = r_wdata1;
    assign sb_busy   = r_busy;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios plus random traffic against a reference model and write scoreboard.
module tb_rf_wb_arb;

    typedef struct packed {
        logic [4:0]  dst;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v   [3];
    logic [4:0]  d   [3];
    logic [63:0] dat [3];
    logic        wb0_ready, wb1_ready, wb2_ready;
    logic        rf_wen0, rf_wen1;
    logic [4:0]  rf_wdst0, rf_wdst1;
    logic [63:0] rf_wdata0, rf_wdata1;
    logic        sb_set_valid = 1'b0;
    logic [4:0]  sb_set_dst = '0;
    logic [31:0] sb_busy;

    int          n_chk = 0;
    int          n_err = 0;
    wr_t         q[$];
    int          m_rr = 0;
    logic [31:0] m_busy = '0;
    logic        m_wen0 = 1'b0, m_wen1 = 1'b0;
    logic [4:0]  m_dst0 = '0, m_dst1 = '0;
    logic [2:0]  obs_rdy;

    always #5 clk = ~clk;

    rf_wb_arb #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(v[0]), .wb0_ready(wb0_ready), .wb0_dst(d[0]), .wb0_data(dat[0]),
        .wb1_valid(v[1]), .wb1_ready(wb1_ready), .wb1_dst(d[1]), .wb1_data(dat[1]),
        .wb2_valid(v[2]), .wb2_ready(wb2_ready), .wb2_dst(d[2]), .wb2_data(dat[2]),
        .rf_wen0(rf_wen0), .rf_wdst0(rf_wdst0), .rf_wdata0(rf_wdata0),
        .rf_wen1(rf_wen1), .rf_wdst1(rf_wdst1), .rf_wdata1(rf_wdata1),
        .sb_set_valid(sb_set_valid), .sb_set_dst(sb_set_dst), .sb_busy(sb_busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: predict grants, check readies, advance the model, check registered outputs.
    task automatic step();
        logic [2:0]  g;
        int          used;
        int          first;
        logic [4:0]  d0, d1;
        logic [31:0] nb;
        wr_t         e;
        g = 3'b000; used = 0; first = 0; d0 = '0; d1 = '0;
        @(negedge clk);
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_rr + k) % 3;
                if (v[i]) begin
                    if (d[i] == 5'd0) begin
                        g[i] = 1'b1;
                    end else if (used == 0) begin
                        g[i] = 1'b1; used = 1; first = i; d0 = d[i];
                        q.push_back({d[i], dat[i]});
                    end else if (used == 1 && d[i] != d0) begin
                        g[i] = 1'b1; used = 2; d1 = d[i];
                        q.push_back({d[i], dat[i]});
                    end
                end
            end
        end
        obs_rdy = {wb2_ready, wb1_ready, wb0_ready};
        chk("ready", {61'd0, obs_rdy}, {61'd0, g});
        @(posedge clk);
        if (rst) begin
            m_rr = 0; m_busy = '0; m_wen0 = 1'b0; m_wen1 = 1'b0;
        end else begin
            nb = m_busy;
            if (m_wen0) nb[m_dst0] = 1'b0;
            if (m_wen1) nb[m_dst1] = 1'b0;
            if (sb_set_valid) nb[sb_set_dst] = 1'b1;
            nb[0] = 1'b0;
            m_busy = nb;
            if (used > 0) m_rr = (first + 1) % 3;
            m_wen0 = (used >= 1);
            m_wen1 = (used >= 2);
            if (used >= 1) m_dst0 = d0;
            if (used >= 2) m_dst1 = d1;
        end
        #1;
        chk("wen0", {63'd0, rf_wen0}, {63'd0, m_wen0});
        chk("wen1", {63'd0, rf_wen1}, {63'd0, m_wen1});
        if (rf_wen0) begin
            if (q.size() == 0) chk("sb_empty0", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk("wdst0", {59'd0, rf_wdst0}, {59'd0, e.dst});
                chk("wdata0", rf_wdata0, e.data);
            end
        end
        if (rf_wen1) begin
            if (q.size() == 0) chk("sb_empty1", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk("wdst1", {59'd0, rf_wdst1}, {59'd0, e.dst});
                chk("wdata1", rf_wdata1, e.data);
            end
        end
        chk("busy", {32'd0, sb_busy}, {32'd0, m_busy});
        chk("rr", {62'd0, dut.r_rr_ptr}, m_rr[63:0]);
        for (int i = 0; i < 3; i++) if (g[i]) v[i] = 1'b0;
    endtask

    task automatic req(input int i, input logic [4:0] dst, input logic [63:0] data);
        v[i] = 1'b1; d[i] = dst; dat[i] = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; d[i] = '0; dat[i] = '0; end
        // Request presented during reset must not be accepted
        req(0, 5'd4, 64'h44);
        do_reset();
        chk("rst_rdy", {61'd0, obs_rdy}, 64'd0);
        chk("rst_wdst0", {59'd0, rf_wdst0}, 64'd0);
        chk("rst_wdata1", rf_wdata1, 64'd0);
        chk("rst_busy", {32'd0, sb_busy}, 64'd0);
        v[0] = 1'b0;

        // Two independent writebacks
        req(0, 5'd5, 64'hA); req(1, 5'd6, 64'hB);
        step();
        chk("two_rdy", {61'd0, obs_rdy}, 64'b011);
        chk("two_dst0", {59'd0, rf_wdst0}, 64'd5);
        chk("two_dat0", rf_wdata0, 64'hA);
        chk("two_dst1", {59'd0, rf_wdst1}, 64'd6);
        chk("two_dat1", rf_wdata1, 64'hB);
        chk("two_rr", {62'd0, dut.r_rr_ptr}, 64'd1);

        // Three requesters, third stalls one cycle
        do_reset();
        req(0, 5'd1, 64'h1); req(1, 5'd2, 64'h2); req(2, 5'd3, 64'h3);
        step();
        chk("three_rdy_a", {61'd0, obs_rdy}, 64'b011);
        step();
        chk("three_rdy_b", {61'd0, obs_rdy}, 64'b100);
        chk("three_dst0", {59'd0, rf_wdst0}, 64'd3);
        chk("three_wen1", {63'd0, rf_wen1}, 64'd0);
        chk("three_rr", {62'd0, dut.r_rr_ptr}, 64'd0);

        // Same destination: serialised in priority order
        req(0, 5'd7, 64'hA); req(1, 5'd7, 64'hB);
        step();
        chk("same_rdy_a", {61'd0, obs_rdy}, 64'b001);
        chk("same_dat_a", rf_wdata0, 64'hA);
        step();
        chk("same_rdy_b", {61'd0, obs_rdy}, 64'b010);
        chk("same_dat_b", rf_wdata0, 64'hB);

        // x0 request rides along without a port
        req(0, 5'd4, 64'h40); req(1, 5'd8, 64'h80); req(2, 5'd0, 64'hDEAD);
        step();
        chk("x0_rdy", {61'd0, obs_rdy}, 64'b111);
        chk("x0_wens", {62'd0, rf_wen1, rf_wen0}, 64'b11);

        // Scoreboard set / clear / set-beats-clear
        sb_set_valid = 1'b1; sb_set_dst = 5'd9;
        step();
        sb_set_valid = 1'b0;
        chk("sb_set", {63'd0, sb_busy[9]}, 64'd1);
        req(0, 5'd9, 64'h99);
        step();
        chk("sb_hold", {63'd0, sb_busy[9]}, 64'd1);
        step();
        chk("sb_clr", {63'd0, sb_busy[9]}, 64'd0);
        sb_set_valid = 1'b1;
        step();
        sb_set_valid = 1'b0;
        req(0, 5'd9, 64'h999);
        step();
        chk("sb_wen9", {59'd0, rf_wdst0}, 64'd9);
        sb_set_valid = 1'b1;
        step();
        sb_set_valid = 1'b0;
        chk("sb_set_wins", {63'd0, sb_busy[9]}, 64'd1);

        // Reset right after a grant
        sb_set_valid = 1'b1; sb_set_dst = 5'd12;
        req(1, 5'd12, 64'hC);
        step();
        sb_set_valid = 1'b0;
        req(0, 5'd3, 64'h33);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_rdy", {61'd0, obs_rdy}, 64'd0);
        chk("mid_rst_wen", {62'd0, rf_wen1, rf_wen0}, 64'd0);
        chk("mid_rst_busy", {32'd0, sb_busy}, 64'd0);
        chk("mid_rst_rr", {62'd0, dut.r_rr_ptr}, 64'd0);
        v[0] = 1'b0;

        // Random traffic, requests held until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++)
                if (!v[i] && $urandom_range(0, 1) == 1)
                    req(i, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            sb_set_valid = ($urandom_range(0, 2) == 0);
            sb_set_dst   = 5'($urandom_range(0, 7));
            rst          = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; sb_set_valid = 1'b0;
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        step();
        step();
        chk("sb_drained", q.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
